// File: rtl/pixel_adc_readout.sv
// Single-slope ADC back-end: ramp generation, per-column code capture on comparator trip,
// and a one-cycle-latency readout of the captured code for the addressed pixel.
module pixel_adc_readout #(
  parameter int unsigned num_pixels = 64,
  parameter int unsigned adc_bits   = 8,
  localparam int unsigned AW        = $clog2(num_pixels) / 2,
  localparam int unsigned N         = 2 ** AW
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                convert,
  input  logic                read,
  input  logic [AW-1:0]       row_addr,
  input  logic [AW-1:0]       col_addr,
  input  logic [N-1:0]        cmp,
  output logic [adc_bits-1:0] dac_code,
  output logic [adc_bits-1:0] pix_data,
  output logic [2*AW-1:0]     pix_addr,
  output logic                pix_valid,
  output logic                frame_done
);

  typedef enum logic [1:0] {StIdle, StConv, StHold, StRead} state_e;

  localparam logic [adc_bits-1:0] CodeMax = {adc_bits{1'b1}};

  state_e              state_q;
  logic [adc_bits-1:0] count_q;
  logic [adc_bits-1:0] latch_q [N];
  logic [N-1:0]        done_q;
  logic [AW-1:0]       row_q;
  logic [adc_bits-1:0] pix_data_q;
  logic [2*AW-1:0]     pix_addr_q;
  logic                pix_valid_q;
  logic                frame_done_q;

  logic [2*AW-1:0] rd_addr;
  logic            rd_last;
  logic            rd_repeat;

  assign rd_addr   = {row_q, col_addr};
  assign rd_last   = &rd_addr;
  // Back-to-back reads of the last pixel report frame completion only once.
  assign rd_repeat = pix_valid_q && (&pix_addr_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      count_q      <= '0;
      done_q       <= '0;
      row_q        <= '0;
      pix_data_q   <= '0;
      pix_addr_q   <= '0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int c = 0; c < N; c++) begin
        latch_q[c] <= '0;
      end
    end else begin
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (convert && (state_q != StConv)) begin
        state_q <= StConv;
        count_q <= '0;
        done_q  <= '0;
        row_q   <= row_addr;
        for (int c = 0; c < N; c++) begin
          latch_q[c] <= '0;
        end
      end else begin
        unique case (state_q)
          StConv: begin
            for (int c = 0; c < N; c++) begin
              if (!done_q[c] && cmp[c]) begin
                latch_q[c] <= count_q;
                done_q[c]  <= 1'b1;
              end else if (!done_q[c] && !convert) begin
                latch_q[c] <= CodeMax;
              end
            end
            if (convert) begin
              if (count_q != CodeMax) begin
                count_q <= count_q + adc_bits'(1);
              end
            end else begin
              count_q <= '0;
              state_q <= StHold;
            end
          end
          StHold, StRead: begin
            if (read) begin
              state_q      <= StRead;
              pix_valid_q  <= 1'b1;
              pix_data_q   <= latch_q[col_addr];
              pix_addr_q   <= rd_addr;
              frame_done_q <= rd_last && !rd_repeat;
            end else begin
              state_q <= StHold;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign dac_code   = count_q;
  assign pix_data   = pix_data_q;
  assign pix_addr   = pix_addr_q;
  assign pix_valid  = pix_valid_q;
  assign frame_done = frame_done_q;

endmodule
